rams_sp_reg_addr_param: RTL and testbench

Parametrised single-port synchronous RAM with registered read address, per-lane write enables, selectable write/read collision mode, and an optional output pipeline register. After every reset, a built-in initialisation sequencer zeroes the whole array one word per cycle and holds off user accesses until it finishes. It is the generic RAM inference target for the block-RAM mapping test family; the width, depth and mode are chosen per instance.

---
 rtl/rams_sp_reg_addr_param.sv | 192 +++++++++++++++++++
 tb/tb_rams_sp_reg_addr_param.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rams_sp_reg_addr_param.sv
// Single-port RAM: per-lane writes, selectable collision mode, optional
// output register, and a post-reset sweep that zeroes every word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         access request (ignored while init_busy)
//   we         write qualifier (with en)
//   be         per-lane write enables, bit i -> di[i*LANE_W +: LANE_W]
//   addr       word address
//   di         write data
//   dout       read data, 1 + OUT_REG cycles after the accepting edge
//   dout_valid dout carries the result of an accepted access
//   init_busy  zeroing sweep in progress
module rams_sp_reg_addr_param #(
    parameter int DATA_W     = 18,
    parameter int LANE_W     = 9,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int WRITE_MODE = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       we,
    input  logic [DATA_W/LANE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          di,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       init_busy
);

    localparam int LANES = DATA_W / LANE_W;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               acc;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [LANES-1:0]   wr_mask;
    logic [DATA_W-1:0]  wr_data;

    logic               in_range;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  old_word;
    logic [DATA_W-1:0]  merged;

    logic               v1_q, v1_d;
    logic [DATA_W-1:0]  d1_q, d1_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the sweep ends on the edge that zeroes the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_A) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs of the FSM: array write port steering and access acceptance
    always_comb begin
        init_busy = 1'b0;
        acc       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = addr;
        wr_mask   = be;
        wr_data   = di;
        unique case (state_q)
            S_INIT: begin
                init_busy = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = cnt_q;
                wr_mask   = '1;
                wr_data   = '0;
            end
            S_RUN: begin
                acc   = en;
                wr_en = en & we & in_range;
            end
        endcase
    end

    assign in_range = 32'(addr) < DEPTH;
    assign rd_word  = mem[addr];
    // Nonexistent words read as zero
    assign old_word = in_range ? rd_word : '0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                merged[i*LANE_W +: LANE_W] = di[i*LANE_W +: LANE_W];
            end
        end
    end

    // Array has no reset; only the sweep clears it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i*LANE_W +: LANE_W] <=
                        wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // First result stage. A dropped (out-of-range) write reports zero in
    // read-first and write-first modes since no word backs the address.
    always_comb begin
        v1_d = 1'b0;
        d1_d = d1_q;
        if (acc) begin
            if (!we) begin
                v1_d = 1'b1;
                d1_d = old_word;
            end else if (WRITE_MODE == 1) begin
                v1_d = 1'b1;
                d1_d = in_range ? merged : '0;
            end else if (WRITE_MODE == 2) begin
                v1_d = v1_q;
            end else begin
                v1_d = 1'b1;
                d1_d = old_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= v1_d;
            d1_q <= d1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2_q;
            logic [DATA_W-1:0] d2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    d2_q <= d1_q;
                end
            end
            assign dout       = d2_q;
            assign dout_valid = v2_q;
        end else begin : g_noreg
            assign dout       = d1_q;
            assign dout_valid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_rams_sp_reg_addr_param.sv
// Bench for rams_sp_reg_addr_param: three instances (read-first,
// write-first + output register, no-change) against a behavioural model.
module tb_rams_sp_reg_addr_param;

    localparam int DW  = 18;
    localparam int LW  = 9;
    localparam int AW  = 10;
    localparam int DEP = 1000;
    localparam int NL  = 2;
    localparam int NI  = 3;
    localparam int MODE [NI] = '{0, 1, 2};
    localparam int LAT  [NI] = '{1, 2, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          we;
    logic [NL-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;

    logic [DW-1:0] dout_w [NI];
    logic          dv_w   [NI];
    logic          ib_w   [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rams_sp_reg_addr_param #(
            .DATA_W    (DW),
            .LANE_W    (LW),
            .ADDR_W    (AW),
            .DEPTH     (DEP),
            .WRITE_MODE(g),
            .OUT_REG   (g == 1 ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .we        (we),
            .be        (be),
            .addr      (addr),
            .di        (di),
            .dout      (dout_w[g]),
            .dout_valid(dv_w[g]),
            .init_busy (ib_w[g])
        );
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mmem [NI][DEP];
    int            init_left;
    // result history: [0] = newest produced stage, [1] = one edge older
    logic          hv [NI][2];
    logic [DW-1:0] hd [NI][2];
    logic          hk [NI][2];

    task automatic model_reset();
        init_left = DEP;
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 2; j++) begin
                hv[k][j] = 1'b0;
                hd[k][j] = '0;
                hk[k][j] = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int k = 0; k < NI; k++) begin
                    hv[k][1] = hv[k][0];
                    hd[k][1] = hd[k][0];
                    hk[k][1] = hk[k][0];
                end
                if (init_left > 0) begin
                    for (int k = 0; k < NI; k++) begin
                        mmem[k][DEP-init_left] = '0;
                        hv[k][0] = 1'b0;
                    end
                    init_left--;
                end else if (!en) begin
                    for (int k = 0; k < NI; k++) hv[k][0] = 1'b0;
                end else begin
                    for (int k = 0; k < NI; k++) begin
                        logic          inr;
                        logic [DW-1:0] oldw, neww;
                        inr  = int'(addr) < DEP;
                        oldw = inr ? mmem[k][addr] : '0;
                        neww = oldw;
                        for (int l = 0; l < NL; l++)
                            if (be[l]) neww[l*LW +: LW] = di[l*LW +: LW];
                        if (we && inr) mmem[k][addr] = neww;
                        if (!we) begin
                            hv[k][0] = 1'b1; hd[k][0] = oldw; hk[k][0] = 1'b1;
                        end else if (MODE[k] == 0) begin
                            hv[k][0] = 1'b1; hd[k][0] = oldw; hk[k][0] = inr;
                        end else if (MODE[k] == 1) begin
                            hv[k][0] = 1'b1; hd[k][0] = neww; hk[k][0] = inr;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                int j;
                j = LAT[k] - 1;
                checks++;
                if (dv_w[k] !== hv[k][j]) begin
                    errors++;
                    $display("FAIL valid inst%0d t=%0t got %b want %b",
                             k, $time, dv_w[k], hv[k][j]);
                end
                if (hk[k][j]) begin
                    checks++;
                    if (dout_w[k] !== hd[k][j]) begin
                        errors++;
                        $display("FAIL dout inst%0d t=%0t got %h want %h",
                                 k, $time, dout_w[k], hd[k][j]);
                    end
                end
                checks++;
                if (ib_w[k] !== (init_left > 0)) begin
                    errors++;
                    $display("FAIL busy inst%0d t=%0t got %b want %b",
                             k, $time, ib_w[k], init_left > 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic pin(input string nm, input int k,
                       input logic [DW-1:0] ed, input logic ev);
        chk({nm, "_d"}, 32'(dout_w[k]), 32'(ed));
        chk({nm, "_v"}, 32'(dv_w[k]), 32'(ev));
    endtask

    task automatic drv(input logic e, input logic w, input logic [NL-1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        en = e; we = w; be = b; addr = a; di = d;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rnd_in();
        int r;
        en = ($urandom_range(3) != 0);
        we = 1'($urandom_range(1));
        be = NL'($urandom_range(3));
        di = DW'($urandom);
        r  = $urandom_range(9);
        if (r == 0)      addr = AW'(DEP + $urandom_range(23));
        else if (r == 1) addr = AW'(DEP - 16 + $urandom_range(15));
        else             addr = AW'($urandom_range(15));
    endtask

    task automatic rnd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rnd_in();
        end
    endtask

    // Counts edges until init_busy falls, poking requests meanwhile.
    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (ib_w[0] && n < DEP + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ib_w[0]) rnd_in();
            else en = 1'b0;
        end
        chk(nm, 32'(n), 32'(DEP));
    endtask

    task automatic release_rst();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic hit_rst(input string nm);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            pin(nm, k, '0, 1'b0);
            chk({nm, "_busy"}, 32'(ib_w[k]), 32'd1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        en = 1'b0; we = 1'b0; be = '0; addr = '0; di = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            pin("rst", k, '0, 1'b0);
            chk("rst_busy", 32'(ib_w[k]), 32'd1);
        end
        release_rst();
        wait_init("init_len");

        // zeroed words after the sweep
        drv(1, 0, 2'b00, 10'd0, '0);
        drv(1, 0, 2'b00, 10'd511, '0);
        pin("rd0", 0, 18'h0, 1'b1);
        drv(1, 0, 2'b00, 10'd1023, '0);
        pin("rd0_oreg", 1, 18'h0, 1'b1);
        idle();
        pin("rd_oor", 2, 18'h0, 1'b1);

        // write then read the last word
        drv(1, 1, 2'b11, 10'd999, 18'h2AAAA);
        drv(1, 0, 2'b00, 10'd999, '0);
        pin("wr_rf", 0, 18'h0, 1'b1);
        idle();
        pin("rdback", 0, 18'h2AAAA, 1'b1);
        pin("rdback_nc", 2, 18'h2AAAA, 1'b1);
        idle();
        pin("rdback_oreg", 1, 18'h2AAAA, 1'b1);

        // streamed reads
        for (int i = 0; i < 16; i++) begin
            drv(1, 0, 2'b00, AW'(i), '0);
            if (i >= 1) chk("stream_v", 32'(dv_w[0]), 32'd1);
            if (i >= 2) chk("stream_v_oreg", 32'(dv_w[1]), 32'd1);
        end
        idle();

        // byte lanes
        drv(1, 1, 2'b11, 10'd5, 18'h3FFFF);
        drv(1, 1, 2'b01, 10'd5, 18'h00000);
        drv(1, 0, 2'b00, 10'd5, '0);
        idle();
        pin("lanes", 0, 18'h3FE00, 1'b1);
        idle();
        pin("lanes_oreg", 1, 18'h3FE00, 1'b1);

        // collision behaviour
        drv(1, 1, 2'b11, 10'd7, 18'h12345);
        drv(1, 0, 2'b00, 10'd7, '0);
        drv(1, 1, 2'b11, 10'd7, 18'h0ABCD);
        pin("pre_col", 0, 18'h12345, 1'b1);
        drv(1, 0, 2'b00, 10'd7, '0);
        pin("col_rf", 0, 18'h12345, 1'b1);
        pin("col_nc", 2, 18'h12345, 1'b1);
        idle();
        pin("col_rd_rf", 0, 18'h0ABCD, 1'b1);
        pin("col_rd_nc", 2, 18'h0ABCD, 1'b1);
        pin("col_wf", 1, 18'h0ABCD, 1'b1);
        idle();
        pin("col_rd_wf", 1, 18'h0ABCD, 1'b1);

        // out-of-range write is dropped, read gives zero
        drv(1, 1, 2'b11, 10'd1010, 18'h3FFFF);
        drv(1, 0, 2'b00, 10'd1010, '0);
        drv(1, 0, 2'b00, 10'd5, '0);
        pin("oor_rd", 0, 18'h0, 1'b1);
        idle();
        pin("oor_keep", 0, 18'h3FE00, 1'b1);

        rnd_cycles(3000);

        // reset with reads in flight
        for (int i = 0; i < 4; i++) drv(1, 0, 2'b00, AW'(i), '0);
        hit_rst("rst_stream");
        rnd_cycles(3);
        release_rst();
        wait_init("init_len2");
        rnd_cycles(1500);

        // reset in the middle of the sweep
        hit_rst("rst_pre");
        release_rst();
        repeat (300) begin
            @(negedge clk);
            rnd_in();
        end
        hit_rst("rst_init");
        release_rst();
        wait_init("init_len3");
        rnd_cycles(1500);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
